// File: rtl/hint_calculator.sv
// Mastermind-style hint engine: counts right-color/right-position (green) and
// right-color/wrong-position (yellow) pins using a sequential, one-compare-per-cycle walk.
module hint_calculator #(
  parameter int unsigned MAX_PINS = 20,
  parameter int unsigned COLOR_W  = 5,
  parameter int unsigned POS_W    = 5
) (
  input  logic                          clk,
  input  logic                          nreset,
  input  logic                          start,
  input  logic [POS_W-1:0]              pins_count,
  input  logic [MAX_PINS*COLOR_W-1:0]   guess,
  input  logic [MAX_PINS*COLOR_W-1:0]   secret,
  output logic                          busy,
  output logic                          done,
  output logic [POS_W-1:0]              green,
  output logic [POS_W-1:0]              yellow
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GREEN  = 2'd1;
  localparam logic [1:0] YELLOW = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]          state, state_nxt;
  logic [POS_W-1:0]    i, i_nxt;
  logic [POS_W-1:0]    j, j_nxt;
  logic [POS_W-1:0]    n;
  logic [POS_W-1:0]    green_nxt, yellow_nxt;
  logic [MAX_PINS-1:0] analyzed_guess, analyzed_guess_nxt;
  logic [MAX_PINS-1:0] analyzed_secret, analyzed_secret_nxt;
  logic [COLOR_W-1:0]  guess_q  [MAX_PINS];
  logic [COLOR_W-1:0]  secret_q [MAX_PINS];

  logic [POS_W-1:0]    n_in;
  logic [POS_W-1:0]    last;
  logic                capture;
  logic                advance;
  logic                i_last;
  logic                pos_match;
  logic                cross_match;

  // Requested pin count saturates at the physical pin count.
  assign n_in        = (pins_count > POS_W'(MAX_PINS)) ? POS_W'(MAX_PINS) : pins_count;
  assign last        = n - POS_W'(1);
  assign i_last      = (i == last);
  assign pos_match   = (guess_q[i] == secret_q[i]);
  assign cross_match = (guess_q[i] == secret_q[j]);

  // Next-state and datapath update.
  always_comb begin
    state_nxt           = state;
    i_nxt               = i;
    j_nxt               = j;
    green_nxt           = green;
    yellow_nxt          = yellow;
    analyzed_guess_nxt  = analyzed_guess;
    analyzed_secret_nxt = analyzed_secret;
    capture             = 1'b0;
    advance             = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          capture             = 1'b1;
          green_nxt           = '0;
          yellow_nxt          = '0;
          analyzed_guess_nxt  = '0;
          analyzed_secret_nxt = '0;
          i_nxt               = '0;
          j_nxt               = '0;
          state_nxt           = (n_in == '0) ? DONE : GREEN;
        end
      end
      GREEN: begin
        if (pos_match) begin
          green_nxt              = green + POS_W'(1);
          analyzed_guess_nxt[i]  = 1'b1;
          analyzed_secret_nxt[i] = 1'b1;
        end
        if (i_last) begin
          state_nxt = YELLOW;
          i_nxt     = '0;
          j_nxt     = '0;
        end else begin
          i_nxt = i + POS_W'(1);
        end
      end
      YELLOW: begin
        // Secret pins already claimed (green or earlier yellow) never match again.
        if (analyzed_guess[i]) begin
          advance = 1'b1;
        end else if (cross_match && !analyzed_secret[j]) begin
          yellow_nxt             = yellow + POS_W'(1);
          analyzed_secret_nxt[j] = 1'b1;
          advance                = 1'b1;
        end else if (j != last) begin
          j_nxt = j + POS_W'(1);
        end else begin
          advance = 1'b1;
        end
        if (advance) begin
          j_nxt = '0;
          if (i_last) begin
            state_nxt = DONE;
            i_nxt     = '0;
          end else begin
            i_nxt = i + POS_W'(1);
          end
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state           <= IDLE;
      i               <= '0;
      j               <= '0;
      n               <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      green           <= '0;
      yellow          <= '0;
      analyzed_guess  <= '0;
      analyzed_secret <= '0;
      for (int unsigned k = 0; k < MAX_PINS; k++) begin
        guess_q[k]  <= '0;
        secret_q[k] <= '0;
      end
    end else begin
      state           <= state_nxt;
      i               <= i_nxt;
      j               <= j_nxt;
      busy            <= (state_nxt != IDLE);
      done            <= (state_nxt == DONE);
      green           <= green_nxt;
      yellow          <= yellow_nxt;
      analyzed_guess  <= analyzed_guess_nxt;
      analyzed_secret <= analyzed_secret_nxt;
      if (capture) begin
        n <= n_in;
        for (int unsigned k = 0; k < MAX_PINS; k++) begin
          guess_q[k]  <= guess[k*COLOR_W +: COLOR_W];
          secret_q[k] <= secret[k*COLOR_W +: COLOR_W];
        end
      end
    end
  end

endmodule
